// File: rtl/alu_issue_stage_if.sv
// Request/result bus for alu_issue_stage.
// Groups the ready/valid request side (operands, opcode, tag) and the
// ready/valid result side (result, flags, tag) of the issue stage.
//   master : producer of requests / consumer of results (e.g. a testbench)
//   slave  : the issue stage itself
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_A;
    logic [DATA_WIDTH-1:0] in_B;
    logic [2:0]            in_ALUop;
    logic [TAG_WIDTH-1:0]  in_tag;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_Result;
    logic                  out_Overflow;
    logic                  out_CarryOut;
    logic                  out_Zero;
    logic [TAG_WIDTH-1:0]  out_tag;

    modport master (
        output in_valid, in_A, in_B, in_ALUop, in_tag, out_ready,
        input  in_ready, out_valid, out_Result, out_Overflow, out_CarryOut,
               out_Zero, out_tag
    );

    modport slave (
        input  in_valid, in_A, in_B, in_ALUop, in_tag, out_ready,
        output in_ready, out_valid, out_Result, out_Overflow, out_CarryOut,
               out_Zero, out_tag
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: one registered request slot (S1) feeding a combinational
// ALU, whose result is buffered in a 2-entry FIFO toward the consumer.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   flush    - synchronous discard of everything in flight
//   bus      - request/result handshake bus (slave side)
//   op_count - number of completed output handshakes (wraps)
module alu_issue_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    alu_issue_stage_if.slave    bus,
    output logic [31:0]         op_count
);
    localparam int ENTRY_W = DATA_WIDTH + 3 + TAG_WIDTH;
    localparam int MSB     = DATA_WIDTH - 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    // ---------------- S1 slot ----------------
    logic                  s1_valid_reg;
    logic [DATA_WIDTH-1:0] s1_a_reg;
    logic [DATA_WIDTH-1:0] s1_b_reg;
    logic [2:0]            s1_op_reg;
    logic [TAG_WIDTH-1:0]  s1_tag_reg;

    // ---------------- ALU ----------------
    logic                  is_sub;
    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH-1:0] sum;
    logic                  carry;
    logic                  overflow;
    logic                  carry_out;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  zero;

    // SUB and both set-less-than ops all evaluate A-B through the adder.
    assign is_sub = (s1_op_reg == OP_SUB) || (s1_op_reg == OP_SLT) ||
                    (s1_op_reg == OP_SLTU);
    assign b_eff  = is_sub ? ~s1_b_reg : s1_b_reg;
    assign {carry, sum} = {1'b0, s1_a_reg} + {1'b0, b_eff} +
                          {{DATA_WIDTH{1'b0}}, is_sub};
    assign overflow  = (s1_a_reg[MSB] == b_eff[MSB]) && (sum[MSB] != s1_a_reg[MSB]);
    // Subtraction reports a borrow, i.e. the inverted adder carry.
    assign carry_out = is_sub ? ~carry : carry;

    always_comb begin
        alu_result = '0;
        unique case (s1_op_reg)
            OP_AND:  alu_result = s1_a_reg & s1_b_reg;
            OP_OR:   alu_result = s1_a_reg | s1_b_reg;
            OP_ADD:  alu_result = sum;
            OP_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, ~carry};
            OP_XOR:  alu_result = s1_a_reg ^ s1_b_reg;
            OP_NOR:  alu_result = ~(s1_a_reg | s1_b_reg);
            OP_SUB:  alu_result = sum;
            OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, sum[MSB] ^ overflow};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // ---------------- handshake control ----------------
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       rd_ptr_reg;
    logic       wr_ptr_reg;
    logic       pop;
    logic       push;
    logic       accept;

    // flush overrides every transfer in its cycle, including the output pop.
    assign pop    = !flush && (count_reg != 2'd0) && bus.out_ready;
    // A full FIFO can still take S1 when the head leaves in the same cycle.
    assign push   = !flush && s1_valid_reg && ((count_reg != 2'd2) || pop);
    assign bus.in_ready = !flush && (!s1_valid_reg || push);
    assign accept = bus.in_valid && bus.in_ready;

    assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= '0;
            s1_tag_reg   <= '0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_a_reg     <= bus.in_A;
            s1_b_reg     <= bus.in_B;
            s1_op_reg    <= bus.in_ALUop;
            s1_tag_reg   <= bus.in_tag;
        end else if (push) begin
            s1_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            op_count   <= 32'd0;
        end else if (flush) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
                op_count   <= op_count + 32'd1;
            end
        end
    end

    // ---------------- result FIFO storage ----------------
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign push_entry = {alu_result, overflow, carry_out, zero, s1_tag_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_entry
            localparam logic IDX = 1'(gi);
            logic [ENTRY_W-1:0] entry_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == IDX)) begin
                    entry_reg <= push_entry;
                end
            end
        end
    endgenerate

    assign head_entry = rd_ptr_reg ? gen_entry[1].entry_reg : gen_entry[0].entry_reg;

    assign bus.out_valid    = (count_reg != 2'd0);
    assign bus.out_Result   = head_entry[ENTRY_W-1 -: DATA_WIDTH];
    assign bus.out_Overflow = head_entry[TAG_WIDTH+2];
    assign bus.out_CarryOut = head_entry[TAG_WIDTH+1];
    assign bus.out_Zero     = head_entry[TAG_WIDTH];
    assign bus.out_tag      = head_entry[TAG_WIDTH-1:0];
endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam longint S32_MAX = 64'sd2147483647;
    localparam longint S32_MIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] op_count;

    alu_issue_stage_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

    alu_issue_stage #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        cout;
        logic        zero;
        logic [4:0]  tag;
        logic [2:0]  op;
        bit          inbuf;   // has reached the output buffer (visible)
    } item_t;

    item_t       q[$];        // every request held by the stage, oldest first
    logic [31:0] model_cnt;
    int          tests  = 0;
    int          failed = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Reference ALU from the arithmetic definitions of each opcode.
    function automatic item_t ref_alu(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] tag);
        item_t  it;
        longint sa, sb, ls;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        it.ovf = 1'b0;
        it.cout = 1'b0;
        it.res = '0;
        case (op)
            OP_AND:  it.res = a & b;
            OP_OR:   it.res = a | b;
            OP_XOR:  it.res = a ^ b;
            OP_NOR:  it.res = ~(a | b);
            OP_ADD: begin
                it.res  = a + b;
                it.cout = (({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF);
                ls      = sa + sb;
                it.ovf  = (ls > S32_MAX) || (ls < S32_MIN);
            end
            OP_SUB: begin
                it.res  = a - b;
                it.cout = (a < b);
                ls      = sa - sb;
                it.ovf  = (ls > S32_MAX) || (ls < S32_MIN);
            end
            OP_SLTU: it.res = (a < b) ? 32'd1 : 32'd0;
            OP_SLT:  it.res = (sa < sb) ? 32'd1 : 32'd0;
            default: it.res = '0;
        endcase
        it.zero  = (it.res == 32'd0);
        it.tag   = tag;
        it.op    = op;
        it.inbuf = 1'b0;
        return it;
    endfunction

    // One clock cycle: drive, check at negedge, advance model at posedge.
    task automatic step(input bit v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input bit ordy, input bit fl, output bit acc);
        bit exp_valid, exp_pop, exp_ready;
        int nbuf;
        bus.in_valid  = v;
        bus.in_ALUop  = op;
        bus.in_A      = a;
        bus.in_B      = b;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        flush         = fl;
        @(negedge clk);
        exp_valid = (q.size() > 0) && q[0].inbuf;
        exp_pop   = exp_valid && ordy && !fl;
        // The stage holds at most three requests, counting after this cycle's pop.
        exp_ready = !fl && ((q.size() - (exp_pop ? 1 : 0)) < 3);
        check("out_valid", bus.out_valid, exp_valid);
        check("in_ready", bus.in_ready, exp_ready);
        check("op_count", op_count, model_cnt);
        if (exp_valid) begin
            check("result", bus.out_Result, q[0].res);
            check("zero", bus.out_Zero, q[0].zero);
            check("tag", bus.out_tag, q[0].tag);
            if (q[0].op == OP_ADD || q[0].op == OP_SUB) begin
                check("overflow", bus.out_Overflow, q[0].ovf);
                check("carryout", bus.out_CarryOut, q[0].cout);
            end
        end
        acc = v && exp_ready;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (exp_pop) begin
                $display("[TB] out tag=%0d result=%08h op=%0d count=%0d",
                         q[0].tag, q[0].res, q[0].op, model_cnt + 32'd1);
                q.delete(0);
                model_cnt = model_cnt + 32'd1;
            end
            nbuf = 0;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].inbuf) begin
                    nbuf++;
                end else begin
                    if (nbuf < 2) q[i].inbuf = 1'b1;
                    break;
                end
            end
            if (acc) q.push_back(ref_alu(op, a, b, tag));
        end
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          acc;
        logic [31:0] saved_cnt;
        logic [31:0] ra, rb;

        model_cnt     = 32'd0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_A      = '0;
        bus.in_B      = '0;
        bus.in_ALUop  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state, before any clock edge.
        #2;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_op_count", op_count, 32'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_result", bus.out_Result, 32'd0);
        check("rst_tag", bus.out_tag, 5'd0);
        flush = 1'b1;
        #1;
        check("rst_in_ready_flush", bus.in_ready, 1'b0);
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Signed overflow on ADD, 2-edge latency.
        step(1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd7, 1, 0, acc);
        step(0, OP_AND, 0, 0, 5'd0, 1, 0, acc);
        check("add_result", bus.out_Result, 32'h8000_0000);
        check("add_ovf", bus.out_Overflow, 1'b1);
        check("add_cout", bus.out_CarryOut, 1'b0);
        check("add_zero", bus.out_Zero, 1'b0);
        step(0, OP_AND, 0, 0, 5'd0, 1, 0, acc);

        // Back-to-back SUB / SLTU / SLT.
        step(1, OP_SUB,  32'd5,          32'd5, 5'd1, 1, 0, acc);
        step(1, OP_SLTU, 32'd1,          32'd2, 5'd2, 1, 0, acc);
        step(1, OP_SLT,  32'hFFFF_FFFF,  32'd1, 5'd3, 1, 0, acc);
        for (int i = 0; i < 4; i++) step(0, OP_AND, 0, 0, 5'd0, 1, 0, acc);
        check("b2b_op_count", op_count, 32'd4);

        // Backpressure: three held, fourth refused, then drained in order.
        for (int t = 1; t <= 4; t++)
            step(1, OP_XOR, $urandom, $urandom, 5'(t), 0, 0, acc);
        check("bp_fourth_refused", {31'd0, acc}, 64'd0);
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++)
            step(1, OP_XOR, 32'h1234, 32'h00FF, 5'd4, 1, 0, acc);
        for (int i = 0; i < 6; i++) step(0, OP_AND, 0, 0, 5'd0, 1, 0, acc);

        // Full FIFO + S1: pop, push and accept in the same cycle.
        for (int t = 1; t <= 3; t++)
            step(1, OP_OR, $urandom, $urandom, 5'(t + 8), 0, 0, acc);
        step(1, OP_NOR, 32'hF0F0_0000, 32'h0F0F_0000, 5'd12, 1, 0, acc);
        check("full_accept", {31'd0, acc}, 64'd1);
        for (int i = 0; i < 6; i++) step(0, OP_AND, 0, 0, 5'd0, 1, 0, acc);

        // Flush with three held requests.
        for (int t = 1; t <= 3; t++)
            step(1, OP_ADD, $urandom, $urandom, 5'(t + 16), 0, 0, acc);
        saved_cnt = model_cnt;
        step(1, OP_SUB, 32'd9, 32'd3, 5'd30, 1, 1, acc);
        step(0, OP_AND, 0, 0, 5'd0, 1, 0, acc);
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_op_count", op_count, saved_cnt);
        step(1, OP_SUB, 32'd9, 32'd3, 5'd21, 1, 0, acc);
        for (int i = 0; i < 3; i++) step(0, OP_AND, 0, 0, 5'd0, 1, 0, acc);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 4; i++)
            step(1, OP_ADD, $urandom, $urandom, 5'(i), (i != 2), 0, acc);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_op_count", op_count, 32'd0);
        check("arst_in_ready", bus.in_ready, 1'b1);
        q.delete();
        model_cnt = 32'd0;
        rst = 1'b0;
        step(1, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd5, 1, 0, acc);
        for (int i = 0; i < 3; i++) step(0, OP_AND, 0, 0, 5'd0, 1, 0, acc);

        // Randomized traffic with backpressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? ra : pick();
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra, rb,
                 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0), acc);
        end
        for (int i = 0; i < 6; i++) step(0, OP_AND, 0, 0, 5'd0, 1, 0, acc);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the operand and result width.
REQ-002 Parameter TAG_WIDTH, default 5, SHALL set the width of the opaque request tag (destination register number).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 flush  input  1  SHALL be a synchronous discard of all in-flight requests.
REQ-006 in_valid  input  1  SHALL mark the request fields below as valid.
REQ-007 in_ready  output  1  SHALL indicate the stage accepts a request this cycle.
REQ-008 in_A, in_B  input  DATA_WIDTH each  SHALL be the operands.
REQ-009 in_ALUop  input  3  SHALL use these codes: AND 000, OR 001, ADD 010, SLTU 011, XOR 100, NOR 101, SUB 110, SLT 111.
REQ-010 in_tag  input  TAG_WIDTH  SHALL be carried unmodified to the output.
REQ-011 out_valid  output  1  SHALL mark the result fields below as valid.
REQ-012 out_ready  input  1  SHALL be the consumer's acceptance.
REQ-013 out_Result  output  DATA_WIDTH  SHALL be the ALU result.
REQ-014 out_Overflow, out_CarryOut, out_Zero  output  1 each  SHALL be the ALU flags.
REQ-015 out_tag  output  TAG_WIDTH  SHALL be the tag of the result.
REQ-016 op_count  output  32  SHALL count completed output handshakes.

Function
REQ-017 A transfer SHALL occur on a cycle where valid and ready are both high at the rising edge; input fields SHALL be ignored otherwise.
REQ-018 Stage 1 (S1) SHALL be a registered slot (valid bit, A, B, ALUop, tag) loaded on an input transfer.
REQ-019 ALU evaluation SHALL be combinational from S1 contents.
REQ-020 Arithmetic: ADD = A+B; SUB = A+~B+1, both mod 2^DATA_WIDTH.
REQ-021 CarryOut SHALL be the carry-out for ADD and the borrow, i.e. inverted carry-out, for SUB.
REQ-022 Overflow SHALL be set when both adder inputs (A and the effective B) share a sign and the sum sign differs; Overflow and CarryOut are don't-care for non-ADD/SUB ops.
REQ-023 SLT SHALL return {0..0, sign(A-B) XOR Overflow}; SLTU SHALL return {0..0, borrow(A-B)}.
REQ-024 Logic ops SHALL be bitwise. Zero SHALL be 1 exactly when Result == 0.
REQ-025 The output buffer SHALL be a 2-entry FIFO of {Result, flags, tag}. out_valid SHALL equal (count != 0). Output fields SHALL present the head entry.
REQ-026 S1 SHALL push into the FIFO when S1 is valid and (count < 2 or an output pop occurs the same cycle).
REQ-027 in_ready SHALL equal !flush && (!S1.valid || S1 pushes this cycle); the resulting combinational out_ready->in_ready path is intended.
REQ-028 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-029 Latency: a request accepted at edge N SHALL appear on the output after edge N+1 if the FIFO has room. Sustained throughput SHALL be 1 request per cycle while out_ready=1.
REQ-030 Backpressure: with out_ready=0, the stage SHALL hold up to 3 requests (2 FIFO + S1); in_ready SHALL then be 0.
REQ-031 Order SHALL be strictly first-in first-out; no request SHALL be dropped or duplicated.
REQ-032 flush=1 SHALL clear S1.valid and the FIFO count at the edge, taking priority over any concurrent push or pop. No output handshake SHALL be counted that cycle, and in_ready SHALL be 0 that cycle.
REQ-033 op_count SHALL increment on each output handshake and wrap from 0xFFFFFFFF to 0.

Reset
REQ-034 While rst=1, without waiting for clk, S1.valid, FIFO count and pointers, and op_count SHALL be 0, and out_valid SHALL be 0.
REQ-035 During reset, in_ready SHALL read 1 unless flush=1.
REQ-036 Reset mid-operation SHALL discard all in-flight requests.
REQ-037 Output data fields SHALL reset to 0.

Verification
REQ-038 ADD A=0x7FFFFFFF B=0x00000001, out_ready=1 -> after 2 edges: Result=0x80000000, Overflow=1, CarryOut=0, Zero=0.
REQ-039 SUB A=5 B=5, then SLTU A=1 B=2, then SLT A=0xFFFFFFFF B=1 back-to-back -> consecutive cycles produce Result 0/Zero=1, then 1, then 1; op_count=3.
REQ-040 out_ready=0, offer 4 requests tagged 1..4 -> tags 1..3 accepted, in_ready=0 on the 4th; raise out_ready -> tags 1,2,3,4 emerge in order.
REQ-041 FIFO full plus S1 valid, out_ready=1 with in_valid=1 -> pop, push and accept all occur in one cycle; count stays 2.
REQ-042 Assert flush with 3 held requests -> next cycle out_valid=0 and op_count is unchanged; a new request completes normally afterwards.
REQ-043 Assert rst asynchronously mid-stream -> out_valid=0 and op_count=0 immediately, without waiting for clk.
